// File: rtl/md_unit.sv
// ----------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the EX stage of a 5-stage MIPS pipeline.
//
// Executes MULT, MULTU, DIV and DIVU over a fixed number of cycles. It also
// handles MTHI/MTLO and holds the architectural HI/LO registers that are read
// by MFHI/MFLO. The result is computed when the operation is accepted and is
// parked in pend_hi/pend_lo. It is committed to HI/LO on the edge that ends
// the busy window. This means the multi-cycle latency is purely architectural
// timing seen by the hazard unit.
//
// Handshake: start is a one-cycle strobe, and op/a/b are valid only while
// start=1. An operation is accepted only when the unit is idle. A start seen
// while busy=1 is dropped entirely, and the hazard unit must never issue one.
//
// Ports:
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous active-low reset, clears all state
//   start     in   1   issue strobe from EX
//   op        in   3   0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=rsvd
//   a         in  32   forwarded rs value
//   b         in  32   forwarded rt value
//   busy      out  1   registered, high while a mul/div is in flight
//   occupied  out  1   (start & op in 1..4) | busy, feeds stall logic
//   hi        out 32   architectural HI
//   lo        out 32   architectural LO
// ----------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        occupied,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_wr_q, pend_wr_d;   // 0 for divide by zero: HI/LO keep old values
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    // ---------------- arithmetic ----------------
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
    logic [31:0] sq_mag, sr_mag, s_quo, s_rem, u_quo, u_rem;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide is done on magnitudes and the signs are reapplied
    // afterwards. This gives truncation toward zero and a remainder that has
    // the sign of the dividend. 0x80000000 / -1 falls out as quotient
    // 0x80000000 and remainder 0, with no special case needed.
    assign a_neg      = a[31];
    assign b_neg      = b[31];
    assign b_zero     = (b == 32'd0);
    assign a_mag      = a_neg ? (32'd0 - a) : a;
    assign b_mag      = b_neg ? (32'd0 - b) : b;
    // The divisor is forced to 1 on divide by zero so the dividers never see 0.
    // That result is discarded through pend_wr anyway.
    assign b_mag_safe = b_zero ? 32'd1 : b_mag;
    assign b_safe     = b_zero ? 32'd1 : b;
    assign sq_mag     = a_mag / b_mag_safe;
    assign sr_mag     = a_mag % b_mag_safe;
    assign s_quo      = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
    assign s_rem      = a_neg ? (32'd0 - sr_mag) : sr_mag;
    assign u_quo      = a / b_safe;
    assign u_rem      = a % b_safe;

    // ---------------- next state ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LD;
                            state_d   = S_RUN;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LD;
                            state_d   = S_RUN;
                        end
                        OP_DIV: begin
                            pend_hi_d = s_rem;
                            pend_lo_d = s_quo;
                            pend_wr_d = !b_zero;
                            cnt_d     = DIV_LD;
                            state_d   = S_RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_d = u_rem;
                            pend_lo_d = u_quo;
                            pend_wr_d = !b_zero;
                            cnt_d     = DIV_LD;
                            state_d   = S_RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Leaving RUN on the edge where the counter reaches zero makes
                // busy high for exactly the loaded number of cycles.
                if (cnt_q == CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // ---------------- outputs ----------------
    assign busy     = (state_q == S_RUN);
    // occupied depends only on start/op/state and never on a, b, hi or lo.
    assign occupied = (start && (op >= OP_MULT) && (op <= OP_DIVU)) || busy;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        occupied;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural HI/LO, and a queue of expected {hi,lo}
    // values, one entry per issued operation.
    logic [31:0] m_hi, m_lo;
    logic [63:0] exp_q[$];

    md_unit #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .occupied(occupied), .hi(hi), .lo(lo)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model ----------------
    // Arithmetic is done with 64-bit integers, then split into HI/LO.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          ix, iy;
        longint      sx, sy, sp, sq, sr;
        logic [63:0] up;
        ix = x; iy = y;
        sx = ix; sy = iy;
        case (o)
            3'd1: begin sp = sx * sy; up = sp; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd2: begin up = {32'd0, x} * {32'd0, y}; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd3: if (y != 0) begin
                sq = sx / sy; sr = sx % sy;
                up = sq; m_lo = up[31:0];
                up = sr; m_hi = up[31:0];
            end
            3'd4: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
            3'd5: m_hi = x;
            3'd6: m_lo = x;
            default: ;
        endcase
    endfunction

    // ---------------- drivers ----------------
    // Caller is at a negedge. Issues a mul/div, counts the busy cycles, and
    // returns at the first negedge with busy=0, which leaves room for a
    // back-to-back issue.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n, want;
        logic [63:0] e;
        want = (o <= 3'd2) ? MULT_N : DIV_N;
        model(o, x, y);
        exp_q.push_back({m_hi, m_lo});
        start = 1'b1; op = o; a = x; b = y;
        #1 chk("occupied_on_start", {63'd0, occupied}, 64'd1);
        @(negedge clk);
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            chk("occupied_while_busy", {63'd0, occupied}, 64'd1);
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'(want));
        e = exp_q.pop_front();
        chk("result_hilo", {hi, lo}, e);
        chk("occupied_after", {63'd0, occupied}, 64'd0);
    endtask

    task automatic mt_op(input logic [2:0] o, input logic [31:0] x);
        model(o, x, 32'd0);
        start = 1'b1; op = o; a = x;
        #1 chk("mt_not_occupied", {63'd0, occupied}, 64'd0);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        #1 chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
        chk("mt_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int n;
        m_hi = 0; m_lo = 0;
        reset = 1'b0; start = 1'b0; op = 3'd0; a = 0; b = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", {61'd0, busy, occupied, 1'b0}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset in the middle of a MULT abandons it.
        start = 1'b1; op = 3'd1; a = 3; b = 4;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
        chk("midrun_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_reset_idle", {62'd0, busy, occupied}, 64'd0);
        chk("after_reset_hilo", {hi, lo}, 64'd0);

        // Directed arithmetic cases.
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3);
        chk("multu", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd4, 32'd7, 32'd2);
        chk("divu_7_2", {hi, lo}, 64'h0000_0001_0000_0003);

        // Divide by zero keeps the preloaded HI/LO.
        mt_op(3'd5, 32'h11);
        mt_op(3'd6, 32'h22);
        run_op(3'd3, 32'd1234, 32'd0);
        chk("div_by_zero", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op(3'd4, 32'd99, 32'd0);
        chk("divu_by_zero", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

        // MTHI issued during busy cycle 3 must be ignored.
        model(3'd1, 32'd1000, 32'hFFFF_FF00);
        start = 1'b1; op = 3'd1; a = 32'd1000; b = 32'hFFFF_FF00;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'hDEAD;
        #1 chk("ignored_occupied", {63'd0, occupied}, 64'd1);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        n = 3;
        while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        chk("ignored_busy_cycles", 64'(n), 64'(MULT_N));
        chk("ignored_mthi_hilo", {hi, lo}, {m_hi, m_lo});
        chk("ignored_occ_after", {63'd0, occupied}, 64'd0);

        // Back-to-back: the second run_op issues on the first cycle busy is 0.
        run_op(3'd1, 32'd12345, 32'd6789);
        run_op(3'd4, 32'hFFFF_FFFF, 32'd10);
        chk("b2b_divu", {hi, lo}, 64'h0000_0005_1999_9999);

        // Randomized operations against the model.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            if (ro >= 3'd5) mt_op(ro, ra);
            else run_op(ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
